stream_checker: RTL and testbench

STREAM_CHECKER -- requirements
Module: stream_checker

---
 rtl/stream_checker.sv | 107 ++++++++++
 tb/tb_stream_checker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_checker.sv
// stream_checker: compares a data stream against a (optionally byte-swapped) expected stream,
// counting mismatches and capturing the first one for a commanded number of words.
module stream_checker #(
    parameter int WIDTH      = 64,
    parameter int SWAP_BYTES = 1,
    parameter int LEN_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_stopOnFail,
    input  logic             cmd_isReady,
    output logic             cmd_canReceive,
    input  logic [WIDTH-1:0] in,
    input  logic             in_isReady,
    output logic             in_canReceive,
    input  logic [WIDTH-1:0] exp,
    input  logic             exp_isReady,
    output logic             exp_canReceive,
    output logic             done,
    output logic             pass,
    output logic [LEN_W-1:0] err_count,
    output logic [LEN_W-1:0] first_idx,
    output logic [WIDTH-1:0] first_got,
    output logic [WIDTH-1:0] first_exp
);
    localparam int NB = WIDTH / 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [LEN_W-1:0] len_q, idx_q, err_q, first_idx_q;
    logic [WIDTH-1:0] first_got_q, first_exp_q, exp_sw;
    logic stop_q, done_q, pass_q, done_d, pass_d;
    logic accept, fire, miss, last;

    for (genvar k = 0; k < NB; k++) begin : g_swap
        assign exp_sw[8*k +: 8] = SWAP_BYTES != 0 ? exp[8*(NB-1-k) +: 8] : exp[8*k +: 8];
    end

    assign accept = cmd_isReady & cmd_canReceive;
    assign fire   = (state_q == RUN) & in_isReady & exp_isReady;
    assign miss   = fire & (in != exp_sw);
    assign last   = (idx_q + 1'b1) == len_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = accept ? (cmd_len == '0 ? DONE : RUN)
                : (fire && (last || (stop_q && miss))) ? DONE : state_q;
    end

    // Reset gates cmd_canReceive so every output reads 0 while rst is low.
    always_comb begin
        cmd_canReceive = rst & (state_q != RUN);
        in_canReceive  = (state_q == RUN) & exp_isReady;
        exp_canReceive = (state_q == RUN) & in_isReady;
    end

    // err_count after this edge is zero unless it already was nonzero or this pair mismatches.
    assign done_d = state_d == DONE;
    assign pass_d = done_d & (accept | (err_q == '0 & ~miss));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q       <= '0;
            stop_q      <= 1'b0;
            idx_q       <= '0;
            err_q       <= '0;
            first_idx_q <= '0;
            first_got_q <= '0;
            first_exp_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            done_q <= done_d;
            pass_q <= pass_d;
            if (accept) begin
                len_q       <= cmd_len;
                stop_q      <= cmd_stopOnFail;
                idx_q       <= '0;
                err_q       <= '0;
                first_idx_q <= '0;
                first_got_q <= '0;
                first_exp_q <= '0;
            end else if (fire) begin
                idx_q <= idx_q + 1'b1;
                if (miss) begin
                    err_q <= err_q != '1 ? err_q + 1'b1 : err_q;
                    if (err_q == '0) begin
                        first_idx_q <= idx_q;
                        first_got_q <= in;
                        first_exp_q <= exp_sw;
                    end
                end
            end
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign first_idx = first_idx_q;
    assign first_got = first_got_q;
    assign first_exp = first_exp_q;
endmodule

// File: tb/tb_stream_checker.sv
// tb_stream_checker: table-driven runs of stream_checker with a scoreboard of per-run results,
// plus hand sequences for mid-run reset and post-reset recovery.
module tb_stream_checker;
    localparam int W  = 64;
    localparam int LW = 32;

    typedef struct {
        int        len;
        bit        stop;
        bit [31:0] bad;
        int        gap;
        bit        inj;
        int        err;
        bit        pass;
        int        cons;
    } vec_t;

    typedef struct {
        logic [LW-1:0] err;
        logic [LW-1:0] fidx;
        logic [W-1:0]  fgot;
        logic [W-1:0]  fexp;
        logic          pass;
        int            cons;
    } exp_t;

    logic          clk = 0, rst = 0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_stopOnFail = 0, cmd_isReady = 0, cmd_canReceive;
    logic [W-1:0]  in = '0, exp = '0;
    logic          in_isReady = 0, exp_isReady = 0, in_canReceive, exp_canReceive;
    logic          done, pass;
    logic [LW-1:0] err_count, first_idx;
    logic [W-1:0]  first_got, first_exp;

    exp_t         sb[$];
    int           n_chk = 0, n_bad = 0;
    logic [W-1:0] inw[32], expw[32];
    vec_t         vt[11];

    always #5 clk = ~clk;

    stream_checker #(.WIDTH(W), .SWAP_BYTES(1), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_len(cmd_len), .cmd_stopOnFail(cmd_stopOnFail),
        .cmd_isReady(cmd_isReady), .cmd_canReceive(cmd_canReceive),
        .in(in), .in_isReady(in_isReady), .in_canReceive(in_canReceive),
        .exp(exp), .exp_isReady(exp_isReady), .exp_canReceive(exp_canReceive),
        .done(done), .pass(pass), .err_count(err_count),
        .first_idx(first_idx), .first_got(first_got), .first_exp(first_exp)
    );

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [W-1:0] bswap(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int k = 0; k < W/8; k++) r[8*k +: 8] = v[8*(W/8-1-k) +: 8];
        return r;
    endfunction

    task automatic build(input vec_t v);
        exp_t e;
        bit   found = 0;
        e.err = LW'(v.err); e.pass = v.pass; e.cons = v.cons;
        e.fidx = '0; e.fgot = '0; e.fexp = '0;
        for (int k = 0; k < v.len; k++) begin
            expw[k] = {$urandom, $urandom};
            inw[k]  = bswap(expw[k]) ^ (v.bad[k] ? ({$urandom, $urandom} | 64'h1) : 64'h0);
            if (v.bad[k] && !found) begin
                found  = 1;
                e.fidx = LW'(k);
                e.fgot = inw[k];
                e.fexp = bswap(expw[k]);
            end
        end
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cmd_rdy"}, cmd_canReceive, 0);
        chk({tag, "_in_rdy"}, in_canReceive, 0);
        chk({tag, "_exp_rdy"}, exp_canReceive, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_fidx"}, first_idx, 0);
        chk({tag, "_fgot"}, first_got, 0);
        chk({tag, "_fexp"}, first_exp, 0);
    endtask

    task automatic run(input vec_t v);
        exp_t e;
        int   ptr = 0, cyc = 0;
        bit   prev;
        build(v);
        @(negedge clk);
        chk("cmd_ready", cmd_canReceive, 1);
        cmd_len = LW'(v.len); cmd_stopOnFail = v.stop; cmd_isReady = 1;
        @(negedge clk);
        cmd_isReady = 0;
        prev = (v.len == 0);
        while (1) begin
            if (done) begin
                chk("done_latency", prev, 1);
                break;
            end
            if (cyc >= 3000) begin
                chk("timeout", 1, 0);
                break;
            end
            in_isReady  = (ptr < v.len) && ($urandom_range(99) >= v.gap);
            exp_isReady = (ptr < v.len) && ($urandom_range(99) >= v.gap);
            in  = ptr < v.len ? inw[ptr] : '0;
            exp = ptr < v.len ? expw[ptr] : '0;
            cmd_isReady = v.inj && cyc == 2;
            cmd_len = 3;
            #1;
            chk("in_rdy_follows_exp", in_canReceive, exp_isReady);
            chk("exp_rdy_follows_in", exp_canReceive, in_isReady);
            if (cmd_isReady) chk("cmd_blocked_in_run", cmd_canReceive, 0);
            prev = in_isReady && exp_isReady && in_canReceive && exp_canReceive;
            if (prev) ptr++;
            @(negedge clk);
            cyc++;
        end
        cmd_isReady = 0;
        in_isReady = 1; exp_isReady = 1;
        #1;
        chk("in_rdy_after_done", in_canReceive, 0);
        chk("exp_rdy_after_done", exp_canReceive, 0);
        in_isReady = 0; exp_isReady = 0;
        e = sb.pop_front();
        chk("consumed", ptr, e.cons);
        chk("done", done, 1);
        chk("pass", pass, e.pass);
        chk("err_count", err_count, e.err);
        chk("first_idx", first_idx, e.fidx);
        chk("first_got", first_got, e.fgot);
        chk("first_exp", first_exp, e.fexp);
    endtask

    initial begin
        exp_t e;
        vt[0]  = '{4,  0, 32'h0,    0,  0, 0, 1, 4};
        vt[1]  = '{8,  0, 32'h24,   0,  0, 2, 0, 8};
        vt[2]  = '{8,  1, 32'h08,   0,  0, 1, 0, 4};
        vt[3]  = '{16, 0, 32'h0,    40, 0, 0, 1, 16};
        vt[4]  = '{16, 0, 32'h1010, 40, 0, 2, 0, 16};
        vt[5]  = '{16, 0, 32'h1010, 0,  0, 2, 0, 16};
        vt[6]  = '{0,  0, 32'h0,    0,  0, 0, 1, 0};
        vt[7]  = '{8,  0, 32'h0,    0,  1, 0, 1, 8};
        vt[8]  = '{8,  1, 32'h0,    0,  0, 0, 1, 8};
        vt[9]  = '{1,  0, 32'h1,    0,  0, 1, 0, 1};
        vt[10] = '{8,  1, 32'h81,   30, 0, 1, 0, 1};

        #2;
        check_all_zero("in_reset");
        @(negedge clk);
        rst = 1;
        #1;
        chk("cmd_rdy_after_release", cmd_canReceive, 1);

        for (int i = 0; i < 11; i++) run(vt[i]);

        build('{8, 0, 32'h2, 0, 0, 0, 0, 0});
        e = sb.pop_front();
        @(negedge clk);
        cmd_len = 8; cmd_stopOnFail = 0; cmd_isReady = 1;
        @(negedge clk);
        cmd_isReady = 0;
        for (int k = 0; k < 3; k++) begin
            in = inw[k]; exp = expw[k]; in_isReady = 1; exp_isReady = 1;
            @(negedge clk);
        end
        chk("mid_err", err_count, 1);
        chk("mid_fidx", first_idx, 1);
        chk("mid_fgot", first_got, e.fgot);
        chk("mid_fexp", first_exp, e.fexp);
        rst = 0;
        #1;
        check_all_zero("mid_reset");
        in_isReady = 0; exp_isReady = 0;
        @(negedge clk);
        rst = 1;
        #1;
        chk("cmd_rdy_after_mid_reset", cmd_canReceive, 1);

        run(vt[1]);
        run(vt[2]);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
